// File: rtl/vram_fetch_pkg.sv
// vram_fetch_pkg: shared widths and FSM state encoding for the VRAM video fetch path
package vram_fetch_pkg;
  localparam int VRAM_AW = 15;
  localparam int VRAM_DW = 8;
  localparam int BIDX_W  = 8;
  localparam int LCNT_W  = 11;
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;
endpackage

// File: rtl/vram_fetch_fifo.sv
// vram_fetch_fifo: small prefetch FIFO holding fetched VRAM bytes ahead of the pixel shifter
module vram_fetch_fifo
  import vram_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push,
  input  logic [VRAM_DW-1:0] i_din,
  input  logic               i_pop,
  input  logic               i_flush,
  output logic [VRAM_DW-1:0] o_dout,
  output logic [AW:0]        o_count,
  output logic               o_empty
);
  logic [VRAM_DW-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wp, r_rp;
  logic [AW:0]        r_cnt;
  logic               w_push, w_pop;
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push && !i_flush && r_cnt != (AW+1)'(DEPTH);
  assign w_pop   = i_pop && !i_flush && !o_empty;
  // Storage array; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= i_din;
  // Pointer and occupancy tracking; flush empties the queue in one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/vram_fetch.sv
// vram_fetch: scanline VRAM reader and 1bpp serialiser; VRAM_FETCH_DOUBLE_SCAN_EN shows each VRAM line twice
module vram_fetch
  import vram_fetch_pkg::*;
#(
  parameter logic [VRAM_AW-1:0] BASE_ADDR      = 15'h0000,
  parameter int                 BYTES_PER_LINE = 40,
  parameter int                 LINES          = 200,
  parameter int                 FIFO_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               line_start,
  input  logic               pix_req,
  output logic [VRAM_AW-1:0] vid_add,
  input  logic [VRAM_DW-1:0] vid_data,
  output logic               pixel,
  output logic               line_done,
  output logic               frame_done,
  output logic               underrun
);
  localparam int CW = $clog2(FIFO_DEPTH);
`ifdef VRAM_FETCH_DOUBLE_SCAN_EN
  localparam int TOTAL = 2 * LINES;
`else
  localparam int TOTAL = LINES;
`endif
  localparam logic [BIDX_W-1:0]  BPL    = BIDX_W'(BYTES_PER_LINE);
  localparam logic [LCNT_W-1:0]  TOT    = LCNT_W'(TOTAL);
  localparam logic [VRAM_AW-1:0] STRIDE = VRAM_AW'(BYTES_PER_LINE);
  state_t             r_state;
  logic [VRAM_AW-1:0] r_line_addr, r_hold_add;
  logic [LCNT_W-1:0]  r_lcnt;
  logic [BIDX_W-1:0]  r_bidx;
  logic               r_rd_v, r_pixel, r_underrun;
  logic [VRAM_DW-1:0] r_sh;
  logic [3:0]         r_sh_n;
  logic [VRAM_DW-1:0] w_dout;
  logic [CW:0]        w_count;
  logic [CW+1:0]      w_pend;
  logic [VRAM_AW-1:0] w_add, w_next_line;
  logic [LCNT_W-1:0]  w_lcnt_inc;
  logic               w_empty, w_late, w_flush, w_issue, w_last, w_adv;
  logic               w_active, w_push, w_load, w_starve;
`ifdef VRAM_FETCH_DOUBLE_SCAN_EN
  assign w_adv = r_lcnt[0];
`else
  assign w_adv = 1'b1;
`endif
  assign w_late      = r_state == FETCH && line_start && !frame_start;
  assign w_flush     = frame_start || w_late;
  assign w_pend      = {1'b0, w_count} + (CW+2)'(r_rd_v);
  assign w_issue     = r_state == FETCH && !w_flush && w_pend < (CW+2)'(FIFO_DEPTH) && r_bidx < BPL;
  assign w_last      = w_issue && r_bidx == BPL - 1'b1;
  assign w_add       = r_line_addr + VRAM_AW'(r_bidx);
  assign w_next_line = r_line_addr + (w_adv ? STRIDE : '0);
  assign w_lcnt_inc  = r_lcnt + 1'b1;
  assign w_active    = r_state == FETCH || r_state == WAIT;
  assign w_push      = r_rd_v && !w_flush;
  assign w_load      = pix_req && w_active && !w_flush && r_sh_n == '0 && !w_empty;
  assign w_starve    = pix_req && w_active && !w_flush && r_sh_n == '0 && w_empty;
  assign vid_add     = w_issue ? w_add : r_hold_add;
  assign line_done   = w_last;
  assign frame_done  = r_state == DONE;
  assign pixel       = r_pixel;
  assign underrun    = r_underrun;
  vram_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (vid_data),
    .i_pop   (w_load),
    .i_flush (w_flush),
    .o_dout  (w_dout),
    .o_count (w_count),
    .o_empty (w_empty)
  );
  // Line sequencing: a late line_start abandons the current line as if it had completed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_line_addr <= BASE_ADDR;
      r_lcnt      <= '0;
      r_bidx      <= '0;
    end else if (frame_start) begin
      r_state     <= IDLE;
      r_line_addr <= BASE_ADDR;
      r_lcnt      <= '0;
      r_bidx      <= '0;
    end else begin
      case (r_state)
        IDLE: if (line_start) begin
          r_state <= FETCH;
          r_bidx  <= '0;
        end
        FETCH: if (line_start) begin
          r_line_addr <= w_next_line;
          r_lcnt      <= w_lcnt_inc;
          r_bidx      <= '0;
          r_state     <= w_lcnt_inc >= TOT ? WAIT : FETCH;
        end else if (w_issue) begin
          r_bidx <= r_bidx + 1'b1;
          if (w_last) begin
            r_line_addr <= w_next_line;
            r_lcnt      <= w_lcnt_inc;
            r_state     <= WAIT;
          end
        end
        WAIT: if (r_lcnt >= TOT) r_state <= DONE;
              else if (line_start) begin
                r_state <= FETCH;
                r_bidx  <= '0;
              end
        default: r_state <= r_state;
      endcase
    end
  // Read pipe: the one outstanding read lands in the FIFO next cycle; address holds when idle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rd_v     <= 1'b0;
      r_hold_add <= BASE_ADDR;
    end else begin
      r_rd_v     <= w_issue;
      r_hold_add <= vid_add;
    end
  // Pixel serialiser, MSB first, with sticky starvation flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pixel    <= 1'b0;
      r_sh       <= '0;
      r_sh_n     <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= frame_start ? 1'b0 : (r_underrun || w_late || w_starve);
      if (w_flush) r_sh_n <= '0;
      else if (pix_req) begin
        if (!w_active) r_pixel <= 1'b0;
        else if (r_sh_n != '0) begin
          r_pixel <= r_sh[7];
          r_sh    <= {r_sh[6:0], 1'b0};
          r_sh_n  <= r_sh_n - 1'b1;
        end else if (!w_empty) begin
          r_pixel <= w_dout[7];
          r_sh    <= {w_dout[6:0], 1'b0};
          r_sh_n  <= 4'd7;
        end else r_pixel <= 1'b0;
      end
    end
endmodule

// File: tb/tb_vram_fetch.sv
// tb_vram_fetch: directed vectors and multi-cycle sequences for vram_fetch
module tb_vram_fetch;
`ifdef VRAM_FETCH_DOUBLE_SCAN_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif
  localparam int NL = DS ? 400 : 200;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fs = 1'b0, ls = 1'b0, pr = 1'b0;
  logic [14:0] va0, va1, va2;
  logic [7:0]  vd0, vd1, vd2;
  logic px0, px1, px2, ld0, ld1, ld2, fd0, fd1, fd2, ur0, ur1, ur2;
  int n_checks = 0, n_err = 0;
  always #5 clk = ~clk;
  vram_fetch u0 (.clk(clk), .rst_n(rst_n), .frame_start(fs), .line_start(ls), .pix_req(pr),
    .vid_add(va0), .vid_data(vd0), .pixel(px0), .line_done(ld0), .frame_done(fd0), .underrun(ur0));
  vram_fetch #(.BASE_ADDR(15'h7FF0)) u1 (.clk(clk), .rst_n(rst_n), .frame_start(fs), .line_start(ls),
    .pix_req(pr), .vid_add(va1), .vid_data(vd1), .pixel(px1), .line_done(ld1), .frame_done(fd1), .underrun(ur1));
  vram_fetch #(.BYTES_PER_LINE(4)) u2 (.clk(clk), .rst_n(rst_n), .frame_start(fs), .line_start(ls),
    .pix_req(pr), .vid_add(va2), .vid_data(vd2), .pixel(px2), .line_done(ld2), .frame_done(fd2), .underrun(ur2));
  always @(posedge clk) begin
    vd0 <= va0[7:0];
    vd1 <= va1[7:0];
    vd2 <= va2[7:0];
  end
  logic        mon_en = 1'b0;
  logic [15:0] prev0, prev1;
  logic [14:0] q0[$], q1[$];
  logic [14:0] ld_a0, ld_a1;
  int          ld_n0 = 0, ld_n1 = 0;
  always @(negedge clk)
    if (!mon_en) begin
      prev0 <= 16'hFFFF;
      prev1 <= 16'hFFFF;
    end else begin
      if ({1'b0, va0} != prev0) begin
        q0.push_back(va0);
        prev0 <= {1'b0, va0};
      end
      if ({1'b0, va1} != prev1) begin
        q1.push_back(va1);
        prev1 <= {1'b0, va1};
      end
      if (ld0) begin
        ld_n0 <= ld_n0 + 1;
        ld_a0 <= va0;
      end
      if (ld1) begin
        ld_n1 <= ld_n1 + 1;
        ld_a1 <= va1;
      end
    end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic drv(input logic f, input logic l, input logic p);
    @(posedge clk);
    #1;
    fs = f;
    ls = l;
    pr = p;
  endtask
  typedef struct {
    logic        fs, ls, pr;
    logic [14:0] va0, va1;
    logic        ld, fd, px, ur;
  } vec_t;
  vec_t tv[9];
  initial begin
    int base0, base1, got, t;
    logic [14:0] hold;
    logic [7:0]  b;
    logic        ok;
    tv[0] = '{1, 0, 0, 15'h0000, 15'h7FF0, 0, 0, 0, 0};
    tv[1] = '{0, 1, 0, 15'h0000, 15'h7FF0, 0, 0, 0, 0};
    tv[2] = '{0, 0, 0, 15'h0000, 15'h7FF0, 0, 0, 0, 0};
    tv[3] = '{0, 0, 0, 15'h0001, 15'h7FF1, 0, 0, 0, 0};
    tv[4] = '{0, 0, 0, 15'h0002, 15'h7FF2, 0, 0, 0, 0};
    tv[5] = '{0, 0, 0, 15'h0003, 15'h7FF3, 0, 0, 0, 0};
    tv[6] = '{0, 0, 0, 15'h0003, 15'h7FF3, 0, 0, 0, 0};
    tv[7] = '{0, 0, 0, 15'h0003, 15'h7FF3, 0, 0, 0, 0};
    tv[8] = '{0, 0, 0, 15'h0003, 15'h7FF3, 0, 0, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst vid_add", 32'(va0), 0);
    chk("rst vid_add base", 32'(va1), 32'h7FF0);
    chk("rst outputs", {28'd0, px0, ld0, fd0, ur0}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drv(tv[i].fs, tv[i].ls, tv[i].pr);
      @(negedge clk);
      chk($sformatf("vec%0d vid_add", i), 32'(va0), 32'(tv[i].va0));
      chk($sformatf("vec%0d vid_add wrap", i), 32'(va1), 32'(tv[i].va1));
      chk($sformatf("vec%0d flags", i), {28'd0, ld0, fd0, px0, ur0},
          {28'd0, tv[i].ld, tv[i].fd, tv[i].px, tv[i].ur});
    end
    drv(0, 0, 1);
    got = 0;
    for (int i = 0; i < 320; i++) begin
      @(posedge clk);
      #1;
      b = 8'(i / 8);
      if (px0 !== b[7 - (i % 8)]) got++;
      if (i == 319) pr = 1'b0;
    end
    chk("pixel stream errors", got, 0);
    chk("no underrun line0", 32'(ur0), 0);
    chk("line0 issue count", q0.size(), 40);
    got = 0;
    for (int i = 0; i < q0.size() && i < 40; i++)
      if (q0[i] !== 15'(i) || q1[i] !== 15'(15'h7FF0 + 15'(i))) got++;
    chk("line0 addr seq errors", got, 0);
    chk("line_done pulses", ld_n0, 1);
    chk("line_done addr", 32'(ld_a0), 39);
    chk("line_done addr wrap", 32'(ld_a1), 32'h0017);
    repeat (20) drv(0, 0, 1);
    drv(0, 0, 0);
    @(negedge clk);
    chk("starve underrun", 32'(ur0), 1);
    chk("starve pixel", 32'(px0), 0);
    base0 = q0.size();
    base1 = q1.size();
    drv(0, 1, 0);
    repeat (8) drv(0, 0, 0);
    chk("line1 issue count", q0.size() - base0, 4);
    chk("line1 start", 32'(q0[base0]), DS ? 0 : 40);
    chk("line1 start wrap", 32'(q1[base1]), DS ? 32'h7FF0 : 32'h0018);
    drv(1, 0, 0);
    drv(0, 0, 0);
    @(negedge clk);
    chk("frame_start clears underrun", 32'(ur0), 0);
    drv(0, 1, 0);
    repeat (6) drv(0, 0, 0);
    drv(0, 0, 1);
    ok = 1'b0;
    for (t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (va0 == 15'd10) ok = 1'b1;
    end
    chk("reach byte10", 32'(ok), 1);
    chk("no underrun before late", 32'(ur0), 0);
    drv(0, 1, 1);
    drv(0, 0, 1);
    @(negedge clk);
    chk("late next addr", 32'(va0), DS ? 0 : 40);
    chk("late next addr wrap", 32'(va1), DS ? 32'h7FF0 : 32'h0018);
    chk("late underrun", 32'(ur0), 1);
    drv(1, 0, 1);
    drv(0, 0, 1);
    for (int s = 0; s < NL; s++) begin
      if (s == NL - 1) begin
        @(negedge clk);
        chk("frame_done before last line", 32'(fd2), 0);
      end
      drv(0, 1, 1);
      drv(0, 0, 1);
      ok = 1'b0;
      for (t = 0; t < 500 && !ok; t++) begin
        @(negedge clk);
        if (ld2) ok = 1'b1;
      end
      chk($sformatf("line%0d done timeout", s), 32'(ok), 1);
      chk($sformatf("line%0d last addr", s), 32'(va2), 32'(((DS ? s / 2 : s) * 4 + 3)));
    end
    @(negedge clk);
    @(negedge clk);
    chk("frame_done after last line", 32'(fd2), 1);
    hold = va2;
    drv(0, 1, 1);
    drv(0, 0, 1);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (va2 !== hold || ld2 !== 1'b0) ok = 1'b0;
    end
    chk("no issue in DONE", 32'(ok), 1);
    chk("frame_done held", 32'(fd2), 1);
    drv(1, 0, 0);
    drv(0, 0, 0);
    @(negedge clk);
    chk("frame_start leaves DONE", 32'(fd2), 0);
    drv(0, 1, 0);
    drv(0, 0, 0);
    @(negedge clk);
    chk("restart addr", 32'(va2), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/vram_fetch.md
Name: vram_fetch

Overview:
- Display-side consumer of the 32 KiB video RAM's video read port.
- Generates sequential 15-bit read addresses per scanline and absorbs the RAM's 1-cycle registered read latency.
- Buffers fetched bytes in a small prefetch FIFO and serialises them into a 1bpp pixel stream for the video timing/DAC stage.
- Driven by frame/line strobes and a pixel-clock enable from the timing generator.

Parameters:
- BASE_ADDR, 15'h0000, VRAM address of byte 0 of line 0.
- BYTES_PER_LINE, 40, bytes fetched per scanline (1..255).
- LINES, 200, active lines per frame (1..1023).
- FIFO_DEPTH, 4, prefetch FIFO entries (power of 2, 2..16).

Ports:
- clk  in  1  system clock, same clock as the video RAM.
- rst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle strobe at frame start.
- line_start  in  1  one-cycle strobe at active-line start.
- pix_req  in  1  pixel enable; one pixel consumed per asserted cycle.
- vid_add  out  15  address to the video RAM video port.
- vid_data  in  8  video RAM read data; valid the cycle after vid_add is presented.
- pixel  out  1  current pixel, registered.
- line_done  out  1  one-cycle pulse when the last byte of a line is issued.
- frame_done  out  1  high in DONE state.
- underrun  out  1  sticky; set when a pixel is requested with shifter and FIFO both empty.

Behaviour:
- Reset: state IDLE, vid_add=BASE_ADDR, pixel=0, line_done=0, frame_done=0, underrun=0, FIFO and shifter empty, line_addr=BASE_ADDR, line count=0.
- States:
  - IDLE → FETCH on line_start.
  - FETCH → WAIT when the last byte of the line is issued.
  - WAIT → FETCH on line_start while line count < LINES.
  - WAIT → DONE when line count reaches LINES.
  - DONE → IDLE only on frame_start.
  - frame_start from any state → IDLE.
- frame_start:
  - Flushes FIFO, shifter and any in-flight read.
  - Sets line_addr=BASE_ADDR and line count=0.
  - Clears underrun.
  - Has priority over a simultaneous line_start; that line_start is ignored.
- Issue rule in FETCH: issue one read per cycle while (fifo_count + inflight) < FIFO_DEPTH and bytes_left > 0.
  - Issuing means vid_add = line_addr + byte_index, mod 2^15 (wrap at 15'h7FFF → 15'h0000).
  - Data returning the next cycle is pushed to the FIFO.
  - inflight is 0 or 1.
- End of line: after the last issue, line_addr += BYTES_PER_LINE (mod 2^15), line count increments, and line_done pulses in that same cycle.
- line_start during FETCH (line late):
  - Remaining bytes of the current line are skipped.
  - FIFO and shifter are flushed.
  - line_addr advances as if the line had completed.
  - The new line starts issuing in the next cycle.
  - underrun is set.
- Pixel path on pix_req:
  - Shifter non-empty: pixel <= shifter MSB, shift left.
  - Shifter empty and FIFO non-empty: load the FIFO head, output its bit7, 7 bits remain.
  - Both empty: pixel <= 0, underrun <= 1.
  - No pix_req: pixel holds.
- Simultaneous FIFO push and pop in one cycle is legal; the count is unchanged.
- FIFO never overflows by construction of the credit rule.
- vid_add holds its last value when not issuing.
- In IDLE and DONE: no issue, and pix_req outputs 0 without setting underrun.

Optional Feature:
- Macro: VRAM_FETCH_DOUBLE_SCAN_EN.
- When defined:
  - Each VRAM line is displayed on two consecutive scanlines.
  - line_addr advances only on the odd scanline of each pair.
  - Line count counts displayed scanlines; DONE is entered at 2*LINES.
- When undefined: every scanline fetches a new VRAM line, as above.

Decomposition:
- Package vram_fetch_pkg:
  - VRAM_AW=15 and VRAM_DW=8.
  - State enum {IDLE, FETCH, WAIT, DONE}.
  - Width helper constants for the byte-index and line counters.
- One natural sub-module: vram_fetch_fifo, a synchronous FIFO with FIFO_DEPTH entries, push/pop/flush inputs, count and empty outputs, and async active-low reset.

Test Plan:
- Reset, then frame_start and line_start, RAM model with byte n = n[7:0], BASE_ADDR=0:
  - vid_add steps 0..39.
  - line_done pulses once at the issue of address 39.
  - pix_req continuous → pixel stream is the MSB-first bits of 0x00, 0x01, …, 0x27.
- pix_req held low after line_start → exactly FIFO_DEPTH reads are issued, then vid_add holds.
- Raising pix_req resumes issuing; no byte is lost or duplicated.
- BASE_ADDR=15'h7FF0 with 40-byte lines → addresses wrap 7FFF→0000 inside line 0; line 1 starts at 15'h0018.
- 200 line_starts → frame_done high after line 199; the 201st line_start issues nothing; frame_start returns to IDLE.
- pix_req asserted 20 cycles before line_start → underrun=1 and pixel=0; a later frame_start clears underrun.
- line_start re-asserted at byte 10 of line 0 → remaining bytes skipped, FIFO flushed, next issue at address 40, underrun=1.
- With VRAM_FETCH_DOUBLE_SCAN_EN → scanlines 0 and 1 both start at address 0 and scanline 2 starts at 40; DONE after 400 line_starts.
